// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue/writeback stage around a registered 4-bit ALU with a 4x4 register file.
// Optional build macro ISSUE_ZERO_REG_EN makes register 0 read as zero and discard writes.
`default_nettype none

module alu_issue_unit #(
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [8:0] instr,
    output logic [3:0] alu_rs,
    output logic [3:0] alu_rt,
    output logic [1:0] alu_arithmetic_mux,
    input  logic [3:0] alu_out,
    output logic       result_valid,
    output logic [3:0] result,
    output logic [1:0] result_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    state_t     state_q, state_d;
    logic       instr_ready_q, instr_ready_d;
    logic [3:0] alu_rs_q, alu_rs_d;
    logic [3:0] alu_rt_q, alu_rt_d;
    logic [1:0] op_q, op_d;
    logic [1:0] rd_q, rd_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] result_q, result_d;
    logic [1:0] result_rd_q, result_rd_d;
    logic [3:0] regs_q [4];
    logic [3:0] regs_d [4];

    logic       accept;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;

    function automatic logic [3:0] read_reg(input logic [1:0] addr, input logic [3:0] rf [4]);
`ifdef ISSUE_ZERO_REG_EN
        return (addr == 2'd0) ? 4'd0 : rf[addr];
`else
        return rf[addr];
`endif
    endfunction

    assign accept = instr_valid && instr_ready_q;

    always_comb begin
        state_d     = state_q;
        alu_rs_d    = alu_rs_q;
        alu_rt_d    = alu_rt_q;
        op_d        = op_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_rd_d = result_rd_q;
        wr_en       = 1'b0;
        wr_addr     = 2'd0;
        wr_data     = 4'd0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (instr[8]) begin
                        result_d    = instr[3:0];
                        result_rd_d = instr[5:4];
                        wr_en       = 1'b1;
                        wr_addr     = instr[5:4];
                        wr_data     = instr[3:0];
                        state_d     = WB;
                    end else begin
                        alu_rs_d = read_reg(instr[3:2], regs_q);
                        alu_rt_d = read_reg(instr[1:0], regs_q);
                        op_d     = instr[7:6];
                        rd_d     = instr[5:4];
                        cnt_d    = LAT;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 3'd0) begin
                    result_d    = alu_out;
                    result_rd_d = rd_q;
                    wr_en       = 1'b1;
                    wr_addr     = rd_q;
                    wr_data     = alu_out;
                    state_d     = WB;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        instr_ready_d = (state_d == IDLE);
    end

    // Register-file write port; the zero-register build drops writes to r0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
`ifdef ISSUE_ZERO_REG_EN
        if (wr_en && (wr_addr != 2'd0)) begin
            regs_d[wr_addr] = wr_data;
        end
`else
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            instr_ready_q <= 1'b0;
            alu_rs_q      <= 4'd0;
            alu_rt_q      <= 4'd0;
            op_q          <= 2'd0;
            rd_q          <= 2'd0;
            cnt_q         <= 3'd0;
            result_q      <= 4'd0;
            result_rd_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 4'd0;
            end
        end else begin
            state_q       <= state_d;
            instr_ready_q <= instr_ready_d;
            alu_rs_q      <= alu_rs_d;
            alu_rt_q      <= alu_rt_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
            result_q      <= result_d;
            result_rd_q   <= result_rd_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign instr_ready        = instr_ready_q;
    assign alu_rs             = alu_rs_q;
    assign alu_rt             = alu_rt_q;
    assign alu_arithmetic_mux = op_q;
    assign result_valid       = (state_q == WB);
    assign result             = result_q;
    assign result_rd          = result_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: one instance at ALU latency 1, one at latency 3.
`default_nettype none

module tb_alu_issue_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       d1_valid = 1'b0, d1_ready, d1_rv;
    logic [8:0] d1_instr = 9'd0;
    logic [3:0] d1_rs, d1_rt, d1_alu_out = 4'd0, d1_result;
    logic [1:0] d1_mux, d1_rd;

    logic       d3_valid = 1'b0, d3_ready, d3_rv;
    logic [8:0] d3_instr = 9'd0;
    logic [3:0] d3_rs, d3_rt, d3_alu_out = 4'd0, d3_result;
    logic [1:0] d3_mux, d3_rd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_issue_unit #(.ALU_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .instr_valid(d1_valid), .instr_ready(d1_ready), .instr(d1_instr),
        .alu_rs(d1_rs), .alu_rt(d1_rt), .alu_arithmetic_mux(d1_mux),
        .alu_out(d1_alu_out),
        .result_valid(d1_rv), .result(d1_result), .result_rd(d1_rd)
    );

    alu_issue_unit #(.ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .instr_valid(d3_valid), .instr_ready(d3_ready), .instr(d3_instr),
        .alu_rs(d3_rs), .alu_rt(d3_rt), .alu_arithmetic_mux(d3_mux),
        .alu_out(d3_alu_out),
        .result_valid(d3_rv), .result(d3_result), .result_rd(d3_rd)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic d1_load(input logic [8:0] ins, input string tag);
        d1_valid = 1'b1;
        d1_instr = ins;
        tick();
        d1_valid = 1'b0;
        d1_instr = 9'h1FF;
        check({tag, " rv"}, 8'(d1_rv), 8'd1);
        check({tag, " result"}, 8'(d1_result), 8'(ins[3:0]));
        check({tag, " rd"}, 8'(d1_rd), 8'(ins[5:4]));
        check({tag, " busy"}, 8'(d1_ready), 8'd0);
        tick();
        check({tag, " rv drop"}, 8'(d1_rv), 8'd0);
        check({tag, " ready"}, 8'(d1_ready), 8'd1);
    endtask

    task automatic d1_op(input logic [8:0] ins, input logic [3:0] exp_rs, input logic [3:0] exp_rt,
                         input logic [3:0] aval, input string tag);
        d1_valid = 1'b1;
        d1_instr = ins;
        tick();
        d1_valid = 1'b0;
        d1_instr = 9'h1FF;
        check({tag, " alu_rs"}, 8'(d1_rs), 8'(exp_rs));
        check({tag, " alu_rt"}, 8'(d1_rt), 8'(exp_rt));
        check({tag, " mux"}, 8'(d1_mux), 8'(ins[7:6]));
        d1_alu_out = ~aval;
        tick();
        check({tag, " rv early"}, 8'(d1_rv), 8'd0);
        d1_alu_out = aval;
        tick();
        check({tag, " rv"}, 8'(d1_rv), 8'd1);
        check({tag, " result"}, 8'(d1_result), 8'(aval));
        check({tag, " rd"}, 8'(d1_rd), 8'(ins[5:4]));
        d1_alu_out = ~aval;
        tick();
        check({tag, " rv drop"}, 8'(d1_rv), 8'd0);
        check({tag, " ready"}, 8'(d1_ready), 8'd1);
        check({tag, " result hold"}, 8'(d1_result), 8'(aval));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        #3;
        check("reset ready", 8'(d1_ready), 8'd0);
        check("reset rv", 8'(d1_rv), 8'd0);
        check("reset outs", {d1_rs, d1_rt}, 8'd0);
        check("reset result", {2'b00, d1_rd, d1_result}, 8'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        check("ready before edge", 8'(d1_ready), 8'd0);
        tick();
        check("ready after edge d1", 8'(d1_ready), 8'd1);
        check("ready after edge d3", 8'(d3_ready), 8'd1);

        // Load r1=5, r2=3; op01 rd3 <- r1,r2; then self-referencing op rd3 <- r3,r1
        d1_load(9'h115, "load r1");
        d1_load(9'h123, "load r2");
        d1_op(9'h076, 4'h5, 4'h3, 4'hA, "op1");
        d1_op(9'h03D, 4'hA, 4'h5, 4'h4, "op self");

        // Back-to-back with instr_valid held high: accepts at E0 and E4
        d1_valid = 1'b1;
        d1_instr = 9'h09B;
        tick();
        check("b2b A rs", {d1_rt, d1_rs}, 8'h43);
        check("b2b A busy", 8'(d1_ready), 8'd0);
        d1_instr = 9'h0E5;
        d1_alu_out = 4'h1;
        tick();
        check("b2b E1 rv", 8'(d1_rv), 8'd0);
        tick();
        check("b2b E2 rv", 8'(d1_rv), 8'd1);
        check("b2b E2 result", {2'b00, d1_rd, d1_result}, 8'h11);
        tick();
        check("b2b E3 ready", 8'(d1_ready), 8'd1);
        check("b2b E3 rs held", 8'(d1_rs), 8'h3);
        tick();
        check("b2b B rs", 8'(d1_rs), 8'h1);
        check("b2b B mux", 8'(d1_mux), 8'h3);
        d1_alu_out = 4'h2;
        tick();
        check("b2b E5 rv", 8'(d1_rv), 8'd0);
        tick();
        d1_valid = 1'b0;
        check("b2b E6 rv", 8'(d1_rv), 8'd1);
        check("b2b E6 result", {2'b00, d1_rd, d1_result}, 8'h22);
        tick();

        // Reset asserted mid-EXEC
        d1_valid = 1'b1;
        d1_instr = 9'h01A;
        tick();
        d1_valid = 1'b0;
        d1_alu_out = 4'h9;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("rst exec rv", 8'(d1_rv), 8'd0);
        check("rst exec ready", 8'(d1_ready), 8'd0);
        check("rst exec ops", {d1_rs, d1_rt}, 8'd0);
        check("rst exec res", {d1_mux, d1_rd, d1_result}, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst exec no rv", 8'(d1_rv), 8'd0);
        tick();
        check("rst exec ready up", 8'(d1_ready), 8'd1);
        d1_op(9'h036, 4'h0, 4'h0, 4'h6, "op after rst");

        // Zero register
        d1_load(9'h107, "load r0");
`ifdef ISSUE_ZERO_REG_EN
        d1_op(9'h010, 4'h0, 4'h0, 4'h3, "op r0");
`else
        d1_op(9'h010, 4'h7, 4'h7, 4'h3, "op r0");
`endif

        // Latency 3: accept E0, capture E4, valid E4-E5, next accept E6
        d3_valid = 1'b1;
        d3_instr = 9'h119;
        tick();
        d3_valid = 1'b0;
        check("d3 load rv", 8'(d3_rv), 8'd1);
        tick();
        d3_valid = 1'b1;
        d3_instr = 9'h065;
        tick();
        d3_valid = 1'b0;
        check("d3 op rs", {d3_rt, d3_rs}, 8'h99);
        check("d3 op mux", 8'(d3_mux), 8'd1);
        d3_alu_out = 4'h0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("d3 E%0d rv", i), 8'(d3_rv), 8'd0);
            if (i == 3) d3_alu_out = 4'hC;
        end
        tick();
        check("d3 E4 rv", 8'(d3_rv), 8'd1);
        check("d3 E4 result", {2'b00, d3_rd, d3_result}, 8'h2C);
        d3_alu_out = 4'h0;
        tick();
        check("d3 E5 rv", 8'(d3_rv), 8'd0);
        check("d3 E5 ready", 8'(d3_ready), 8'd1);
        d3_valid = 1'b1;
        d3_instr = 9'h131;
        tick();
        d3_valid = 1'b0;
        check("d3 E6 accept", 8'(d3_rv), 8'd1);
        check("d3 E6 result", {2'b00, d3_rd, d3_result}, 8'h31);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
